// File: rtl/tristate_serial_tx_pkg.sv
// Shared types and constants for the tri-state serial frame transmitter.
// Holds the FSM state encoding and the pad polarity/line-level constants.
package tristate_serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_GUARD = 3'd5
  } tx_state_e;

  // Tri-state buffer control polarity.
  localparam logic PAD_HIZ   = 1'b1;
  localparam logic PAD_DRIVE = 1'b0;

  // Line levels: mark (idle/stop/guard) and space (start bit).
  localparam logic LINE_MARK  = 1'b1;
  localparam logic LINE_SPACE = 1'b0;

endpackage

// File: rtl/tristate_serial_tx_if.sv
// Upstream valid/ready word handshake into the transmitter.
//   tx_data  : payload word, sampled on accept
//   tx_valid : upstream has a word
//   tx_ready : transmitter can accept a word this cycle
interface tristate_serial_tx_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/tristate_serial_tx_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the bit period (state entry)
//   tick       : high on the last cycle of each bit period
module bit_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  // Wrap to zero on the terminal count so the counter never passes it.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tristate_serial_tx.sv
// Half-duplex framed serial transmitter feeding a pad tri-state buffer.
// Frame: LEAD(1) START(0) DATA LSB-first STOP(1) then GUARD(1) before release.
//   clk, rst_n : clock, async active-low reset
//   tx_if      : valid/ready word handshake (slave side)
//   busy       : state is not IDLE
//   pad_o      : serial data into the buffer (registered)
//   pad_t      : buffer tristate control, 1 = high-Z (registered)
module tristate_serial_tx
  import tristate_serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned GUARD_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tristate_serial_tx_if.slave  tx_if,
  output logic                 busy,
  output logic                 pad_o,
  output logic                 pad_t
);

  localparam int unsigned BIT_MAX = (DATA_W > GUARD_BITS) ? DATA_W : GUARD_BITS;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] GUARD_LAST = BIT_W'(GUARD_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              pad_o_q, pad_o_d;
  logic              pad_t_q, pad_t_d;
  logic              tx_ready_c;
  logic              tick;
  logic              clear_c;

  bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_c),
    .tick  (tick)
  );

  assign tx_if.tx_ready = tx_ready_c;
  assign busy           = (state_q != ST_IDLE);
  assign pad_o          = pad_o_q;
  assign pad_t          = pad_t_q;

  // Next-state, counters, shift register and next pad levels.
  // Pads are computed from the current state, so they trail the state by one cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_ready_c = 1'b0;
    pad_o_d    = LINE_MARK;
    pad_t_d    = PAD_DRIVE;

    unique case (state_q)
      ST_IDLE: begin
        tx_ready_c = 1'b1;
        pad_t_d    = PAD_HIZ;
        if (tx_if.tx_valid) state_d = ST_LEAD;
      end
      ST_LEAD: begin
        if (tick) state_d = ST_START;
      end
      ST_START: begin
        pad_o_d = LINE_SPACE;
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        pad_o_d = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) state_d = ST_STOP;
          else                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      ST_STOP: begin
        // Only the last stop cycle may accept, giving a gapless back-to-back frame.
        tx_ready_c = tick;
        if (tick) state_d = tx_if.tx_valid ? ST_START : ST_GUARD;
      end
      ST_GUARD: begin
        tx_ready_c = 1'b1;
        if (tx_if.tx_valid) begin
          state_d = ST_START;
        end else if (tick) begin
          if (bit_cnt_q == GUARD_LAST) state_d = ST_IDLE;
          else                         bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tx_if.tx_valid && tx_ready_c) shift_d = tx_if.tx_data;
    if (state_d != state_q)           bit_cnt_d = '0;

    // Bit timer restarts on every state entry and is held while idle.
    clear_c = (state_d != state_q) || (state_q == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      pad_o_q   <= LINE_MARK;
      pad_t_q   <= PAD_HIZ;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      pad_o_q   <= pad_o_d;
      pad_t_q   <= pad_t_d;
    end
  end

endmodule

// File: tb/tb_tristate_serial_tx.sv
// Directed bench for tristate_serial_tx with C=4, DATA_W=8, GUARD_BITS=1.
// Expected pad waveforms are built per cycle from hand-specified frames.
module tb_tristate_serial_tx;

  localparam int unsigned C  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned GB = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic busy, pad_o, pad_t;

  tristate_serial_tx_if #(.DATA_W(DW)) tx_if ();

  tristate_serial_tx #(
    .CLKS_PER_BIT (C),
    .DATA_W       (DW),
    .GUARD_BITS   (GB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx_if (tx_if),
    .busy  (busy),
    .pad_o (pad_o),
    .pad_t (pad_t)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit exp_q[$];   // expected pad_o per cycle k=1..N after accept; pad_t=0 over the same span

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic push_level(input bit lvl, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(lvl);
  endtask

  task automatic push_frame(input logic [DW-1:0] w, input bit lead);
    if (lead) push_level(1'b1, C);
    push_level(1'b0, C);
    for (int b = 0; b < DW; b++) push_level(w[b], C);
    push_level(1'b1, C);
  endtask

  // Present a word and return right after the posedge on which it is accepted.
  task automatic wait_accept(input logic [DW-1:0] w, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = w;
    for (int i = 0; i < 200; i++) begin
      if (tx_if.tx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    vectors++;
    if ({pad_t, pad_o, tx_if.tx_ready, busy} !== 4'b1110) begin
      miscompares++;
      $display("FAIL reset_hold: {pad_t,pad_o,ready,busy} got %b want 1110",
               {pad_t, pad_o, tx_if.tx_ready, busy});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      vectors++;
      if ({pad_t, pad_o, tx_if.tx_ready, busy} !== 4'b1110) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: {pad_t,pad_o,ready,busy} got %b want 1110",
                 k, {pad_t, pad_o, tx_if.tx_ready, busy});
      end
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    int n, low_cnt;
    logic exp_o, exp_t, exp_b, exp_r;
    exp_q.delete();
    push_frame(8'hA5, 1'b1);
    push_level(1'b1, C * GB);
    n = exp_q.size();
    low_cnt = 0;
    wait_accept(8'hA5, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_accept: ok got 0 want 1");
    end
    for (int k = 0; k <= n + 3; k++) begin
      @(negedge clk);
      if (k == 0) tx_if.tx_valid = 1'b0;
      exp_o = (k >= 1 && k <= n) ? exp_q[k-1] : 1'b1;
      exp_t = (k >= 1 && k <= n) ? 1'b0 : 1'b1;
      exp_b = (k < n);
      exp_r = (k >= n - int'(C * GB) - 1);
      if (pad_t === 1'b0) low_cnt++;
      vectors++;
      if ({pad_t, pad_o, busy, tx_if.tx_ready} !== {exp_t, exp_o, exp_b, exp_r}) begin
        miscompares++;
        $display("FAIL single_frame cycle %0d: {pad_t,pad_o,busy,ready} got %b want %b",
                 k, {pad_t, pad_o, busy, tx_if.tx_ready}, {exp_t, exp_o, exp_b, exp_r});
      end
    end
    vectors++;
    if (low_cnt != 48) begin
      miscompares++;
      $display("FAIL single_drive_len: pad_t low cycles got %0d want 48", low_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, drop;
    int n, accepts, acc_k;
    logic exp_o, exp_t;
    exp_q.delete();
    push_frame(8'h00, 1'b1);
    push_frame(8'hFF, 1'b0);
    push_level(1'b1, C * GB);
    n = exp_q.size();
    drop = 1'b0;
    acc_k = -1;
    wait_accept(8'h00, ok);
    accepts = ok ? 1 : 0;
    for (int k = 0; k <= n + 3; k++) begin
      @(negedge clk);
      if (k == 0) tx_if.tx_data = 8'hFF;
      if (drop) begin
        tx_if.tx_valid = 1'b0;
        drop = 1'b0;
      end
      exp_o = (k >= 1 && k <= n) ? exp_q[k-1] : 1'b1;
      exp_t = (k >= 1 && k <= n) ? 1'b0 : 1'b1;
      vectors++;
      if ({pad_t, pad_o} !== {exp_t, exp_o}) begin
        miscompares++;
        $display("FAIL b2b_frame cycle %0d: {pad_t,pad_o} got %b want %b",
                 k, {pad_t, pad_o}, {exp_t, exp_o});
      end
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        accepts++;
        acc_k = k + 1;
        drop = 1'b1;
      end
    end
    tx_if.tx_valid = 1'b0;
    vectors++;
    if (accepts != 2) begin
      miscompares++;
      $display("FAIL b2b_accepts: got %0d want 2", accepts);
    end
    vectors++;
    if (acc_k != 44) begin
      miscompares++;
      $display("FAIL b2b_accept_edge: got %0d want 44", acc_k);
    end
  endtask

  task automatic test_guard_accept();
    bit ok;
    int n, accepts;
    logic exp_o, exp_t;
    exp_q.delete();
    push_frame(8'h5A, 1'b1);
    push_level(1'b1, 2);
    push_frame(8'hC3, 1'b0);
    push_level(1'b1, C * GB);
    n = exp_q.size();
    wait_accept(8'h5A, ok);
    accepts = ok ? 1 : 0;
    for (int k = 0; k <= n + 3; k++) begin
      @(negedge clk);
      if (k == 0 || k == 46) tx_if.tx_valid = 1'b0;
      if (k == 45) begin
        vectors++;
        if (tx_if.tx_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL guard_ready: tx_ready got %b want 1", tx_if.tx_ready);
        end
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'hC3;
      end
      exp_o = (k >= 1 && k <= n) ? exp_q[k-1] : 1'b1;
      exp_t = (k >= 1 && k <= n) ? 1'b0 : 1'b1;
      vectors++;
      if ({pad_t, pad_o} !== {exp_t, exp_o}) begin
        miscompares++;
        $display("FAIL guard_frame cycle %0d: {pad_t,pad_o} got %b want %b",
                 k, {pad_t, pad_o}, {exp_t, exp_o});
      end
      if (tx_if.tx_valid && tx_if.tx_ready) accepts++;
    end
    vectors++;
    if (accepts != 2) begin
      miscompares++;
      $display("FAIL guard_accepts: got %0d want 2", accepts);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int n, accepts;
    logic exp_o, exp_t;
    exp_q.delete();
    push_frame(8'h96, 1'b1);
    push_level(1'b1, C * GB);
    n = exp_q.size();
    wait_accept(8'h96, ok);
    accepts = ok ? 1 : 0;
    for (int k = 0; k <= n + 3; k++) begin
      @(negedge clk);
      if (k == 0 || k == 21) tx_if.tx_valid = 1'b0;
      if (k == 20) begin
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'hFF;
        vectors++;
        if (tx_if.tx_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_ready: tx_ready got %b want 0", tx_if.tx_ready);
        end
      end
      exp_o = (k >= 1 && k <= n) ? exp_q[k-1] : 1'b1;
      exp_t = (k >= 1 && k <= n) ? 1'b0 : 1'b1;
      vectors++;
      if ({pad_t, pad_o} !== {exp_t, exp_o}) begin
        miscompares++;
        $display("FAIL stall_frame cycle %0d: {pad_t,pad_o} got %b want %b",
                 k, {pad_t, pad_o}, {exp_t, exp_o});
      end
      if (tx_if.tx_valid && tx_if.tx_ready) accepts++;
    end
    vectors++;
    if (accepts != 1) begin
      miscompares++;
      $display("FAIL stall_accepts: got %0d want 1", accepts);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int n;
    logic exp_o, exp_t;
    wait_accept(8'hFF, ok);
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      if (k == 0) tx_if.tx_valid = 1'b0;
    end
    vectors++;
    if ({busy, pad_t} !== 2'b10) begin
      miscompares++;
      $display("FAIL midreset_pre: {busy,pad_t} got %b want 10", {busy, pad_t});
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({pad_t, pad_o, tx_if.tx_ready, busy} !== 4'b1110) begin
      miscompares++;
      $display("FAIL midreset_async: {pad_t,pad_o,ready,busy} got %b want 1110",
               {pad_t, pad_o, tx_if.tx_ready, busy});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    push_frame(8'h3C, 1'b1);
    push_level(1'b1, C * GB);
    n = exp_q.size();
    wait_accept(8'h3C, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL midreset_accept: ok got 0 want 1");
    end
    for (int k = 0; k <= n + 3; k++) begin
      @(negedge clk);
      if (k == 0) tx_if.tx_valid = 1'b0;
      exp_o = (k >= 1 && k <= n) ? exp_q[k-1] : 1'b1;
      exp_t = (k >= 1 && k <= n) ? 1'b0 : 1'b1;
      vectors++;
      if ({pad_t, pad_o} !== {exp_t, exp_o}) begin
        miscompares++;
        $display("FAIL midreset_frame cycle %0d: {pad_t,pad_o} got %b want %b",
                 k, {pad_t, pad_o}, {exp_t, exp_o});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_guard_accept();
    test_stall();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
